// File: rtl/sweep_ctrl.sv
// sweep_ctrl: frequency-sweep sequencer. Retunes the DDS per point, discards settle strobes,
// sums n_avg decimated I/Q strobes and hands out one result per point. Optional watchdog: SWEEP_CTRL_TIMEOUT_EN.
module sweep_ctrl #(
  parameter int unsigned DW = 31,
  parameter int unsigned NW = 12,
  parameter int unsigned AW = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic               abort,
  input  logic [31:0]        ftw_start,
  input  logic [31:0]        ftw_step,
  input  logic [NW-1:0]      n_points,
  input  logic [AW-1:0]      settle,
  input  logic [AW-1:0]      n_avg,
  input  logic               strobe_in,
  input  logic [DW-1:0]      i_in,
  input  logic [DW-1:0]      q_in,
  output logic [31:0]        dds_ftw,
  output logic               busy,
  output logic               done,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [DW+AW-1:0]   res_i,
  output logic [DW+AW-1:0]   res_q,
  output logic [NW-1:0]      res_idx
`ifdef SWEEP_CTRL_TIMEOUT_EN
  ,
  output logic               err
`endif
);

  localparam int unsigned SW = DW + AW;

  typedef enum logic [1:0] {IDLE, SETTLE, ACCUM, EMIT} state_t;

  state_t          state;
  logic [31:0]     step_q;
  logic [NW-1:0]   npts_q;
  logic [AW-1:0]   settle_q;
  logic [AW-1:0]   navg_q;
  logic [AW-1:0]   set_cnt;
  logic [AW-1:0]   avg_cnt;
  logic [SW-1:0]   i_ext;
  logic [SW-1:0]   q_ext;
  logic            last_pt;
`ifdef SWEEP_CTRL_TIMEOUT_EN
  logic [15:0]     wdog;
`endif

  assign i_ext   = {{AW{i_in[DW-1]}}, i_in};
  assign q_ext   = {{AW{q_in[DW-1]}}, q_in};
  assign last_pt = (res_idx == npts_q - NW'(1));

  // res_i/res_q double as the accumulators; they are frozen in EMIT
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      step_q    <= '0;
      npts_q    <= '0;
      settle_q  <= '0;
      navg_q    <= '0;
      set_cnt   <= '0;
      avg_cnt   <= '0;
      dds_ftw   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      res_valid <= 1'b0;
      res_i     <= '0;
      res_q     <= '0;
      res_idx   <= '0;
`ifdef SWEEP_CTRL_TIMEOUT_EN
      err       <= 1'b0;
      wdog      <= '0;
`endif
    end else begin
      done <= 1'b0;
`ifdef SWEEP_CTRL_TIMEOUT_EN
      if (strobe_in || !(state == SETTLE || state == ACCUM)) wdog <= '0;
      else                                                   wdog <= wdog + 16'd1;
`endif
      if (abort) begin
        state     <= IDLE;
        busy      <= 1'b0;
        res_valid <= 1'b0;
      end
`ifdef SWEEP_CTRL_TIMEOUT_EN
      else if (wdog == 16'hFFFF) begin
        err       <= 1'b1;
        state     <= IDLE;
        busy      <= 1'b0;
        res_valid <= 1'b0;
      end
`endif
      else begin
        case (state)
          IDLE: begin
            if (start) begin
              step_q   <= ftw_step;
              npts_q   <= (n_points == '0) ? NW'(1) : n_points;
              settle_q <= settle;
              navg_q   <= (n_avg == '0) ? AW'(1) : n_avg;
              dds_ftw  <= ftw_start;
              res_idx  <= '0;
              set_cnt  <= '0;
              busy     <= 1'b1;
              state    <= SETTLE;
`ifdef SWEEP_CTRL_TIMEOUT_EN
              err      <= 1'b0;
`endif
            end
          end
          SETTLE: begin
            if (settle_q == '0 || (strobe_in && (set_cnt + AW'(1)) == settle_q)) begin
              res_i   <= '0;
              res_q   <= '0;
              avg_cnt <= '0;
              state   <= ACCUM;
            end else if (strobe_in) begin
              set_cnt <= set_cnt + AW'(1);
            end
          end
          ACCUM: begin
            if (strobe_in) begin
              res_i   <= res_i + i_ext;
              res_q   <= res_q + q_ext;
              avg_cnt <= avg_cnt + AW'(1);
              if ((avg_cnt + AW'(1)) == navg_q) begin
                res_valid <= 1'b1;
                state     <= EMIT;
              end
            end
          end
          EMIT: begin
            if (res_ready) begin
              res_valid <= 1'b0;
              if (last_pt) begin
                done  <= 1'b1;
                busy  <= 1'b0;
                state <= IDLE;
              end else begin
                res_idx <= res_idx + NW'(1);
                dds_ftw <= dds_ftw + step_q;
                set_cnt <= '0;
                state   <= SETTLE;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sweep_ctrl.sv
// tb_sweep_ctrl: randomized self-checking bench for sweep_ctrl against a per-point sum/tuning-word model.
// Define SWEEP_CTRL_TIMEOUT_EN to also exercise the watchdog.
module tb_sweep_ctrl;
  localparam int unsigned DW = 31;
  localparam int unsigned NW = 12;
  localparam int unsigned AW = 8;
  localparam int unsigned SW = DW + AW;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [31:0]   ftw_start = '0;
  logic [31:0]   ftw_step = '0;
  logic [NW-1:0] n_points = '0;
  logic [AW-1:0] settle = '0;
  logic [AW-1:0] n_avg = '0;
  logic          strobe_in = 1'b0;
  logic [DW-1:0] i_in = '0;
  logic [DW-1:0] q_in = '0;
  logic          res_ready = 1'b0;
  logic [31:0]   dds_ftw;
  logic          busy, done, res_valid;
  logic [SW-1:0] res_i, res_q;
  logic [NW-1:0] res_idx;
`ifdef SWEEP_CTRL_TIMEOUT_EN
  logic          err;
`endif

  int total = 0;
  int bad = 0;

  sweep_ctrl #(.DW(DW), .NW(NW), .AW(AW)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .ftw_start(ftw_start), .ftw_step(ftw_step), .n_points(n_points),
    .settle(settle), .n_avg(n_avg), .strobe_in(strobe_in), .i_in(i_in), .q_in(q_in),
    .dds_ftw(dds_ftw), .busy(busy), .done(done), .res_valid(res_valid),
    .res_ready(res_ready), .res_i(res_i), .res_q(res_q), .res_idx(res_idx)
`ifdef SWEEP_CTRL_TIMEOUT_EN
    , .err(err)
`endif
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full sweep. Model: point p tunes to fs + p*step; of the strobes delivered in a point,
  // the first `settle` are dropped and the next max(n_avg,1) are summed.
  task automatic run_sweep(input logic [31:0] fs, input logic [31:0] fst, input int np, input int st,
                           input int na, input int gap, input int bp, input bit cdata,
                           input logic [DW-1:0] ci, input logic [DW-1:0] cq, input bit poke,
                           output logic [SW-1:0] lr_i, output logic [31:0] lf);
    int pts, navg, gp, bpn;
    logic [31:0] ef;
    logic [DW-1:0] iv, qv;
    logic [SW-1:0] e_i, e_q;
    longint si, sq;
    bit unstable;
    pts  = (np == 0) ? 1 : np;
    navg = (na == 0) ? 1 : na;
    ftw_start = fs; ftw_step = fst; n_points = NW'(np); settle = AW'(st); n_avg = AW'(na);
    start = 1'b1;
    tick();
    start = 1'b0;
    ftw_start = $urandom; ftw_step = $urandom;
    n_points = NW'($urandom); settle = AW'($urandom); n_avg = AW'($urandom);
    total++;
    if (busy !== 1'b1 || dds_ftw !== fs || res_idx !== '0)
      $display("FAIL start: busy=%b ftw=%h idx=%0d want busy=1 ftw=%h idx=0", busy, dds_ftw, res_idx, fs);
    for (int p = 0; p < pts; p++) begin
      ef = fs + 32'(p) * fst;
      si = 0; sq = 0;
      tick();
      total++;
      if (dds_ftw !== ef || res_idx !== NW'(p) || res_valid !== 1'b0 || busy !== 1'b1) begin
        bad++;
        $display("FAIL point_entry p=%0d: ftw=%h idx=%0d valid=%b busy=%b want ftw=%h idx=%0d valid=0 busy=1",
                 p, dds_ftw, res_idx, res_valid, busy, ef, p);
      end
      for (int k = 0; k < st + navg; k++) begin
        iv = cdata ? ci : DW'($urandom);
        qv = cdata ? cq : DW'($urandom);
        i_in = iv; q_in = qv; strobe_in = 1'b1;
        if (poke && k == 0) begin start = 1'b1; ftw_start = $urandom; end
        tick();
        strobe_in = 1'b0; start = 1'b0;
        if (k >= st) begin
          si += longint'($signed(iv));
          sq += longint'($signed(qv));
        end
        if (k == st + navg - 1) begin
          total++;
          if (res_valid !== 1'b1) begin
            bad++;
            $display("FAIL valid_timing p=%0d: res_valid=%b want 1", p, res_valid);
          end
        end else begin
          gp = (gap > 0) ? gap : $urandom_range(1, 5);
          for (int g = 1; g < gp; g++) tick();
        end
      end
      e_i = SW'(si); e_q = SW'(sq);
      total++;
      if (res_i !== e_i || res_q !== e_q || res_idx !== NW'(p) || dds_ftw !== ef) begin
        bad++;
        $display("FAIL result p=%0d: i=%0d q=%0d idx=%0d ftw=%h want i=%0d q=%0d idx=%0d ftw=%h",
                 p, $signed(res_i), $signed(res_q), res_idx, dds_ftw, si, sq, p, ef);
      end
      bpn = (bp >= 0) ? bp : $urandom_range(0, -bp);
      unstable = 1'b0;
      for (int c = 0; c < bpn; c++) begin
        strobe_in = (c % 3 == 0);
        i_in = DW'($urandom); q_in = DW'($urandom);
        tick();
        strobe_in = 1'b0;
        if (res_valid !== 1'b1 || res_i !== e_i || res_q !== e_q || res_idx !== NW'(p) ||
            dds_ftw !== ef || busy !== 1'b1)
          unstable = 1'b1;
      end
      if (bpn > 0) begin
        total++;
        if (unstable) begin
          bad++;
          $display("FAIL hold p=%0d: outputs moved under backpressure, now i=%0d idx=%0d ftw=%h want i=%0d idx=%0d ftw=%h",
                   p, $signed(res_i), res_idx, dds_ftw, si, p, ef);
        end
      end
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      total++;
      if (res_valid !== 1'b0 || done !== (p == pts - 1) || busy !== (p != pts - 1)) begin
        bad++;
        $display("FAIL handshake p=%0d: valid=%b done=%b busy=%b want valid=0 done=%b busy=%b",
                 p, res_valid, done, busy, p == pts - 1, p != pts - 1);
      end
      lr_i = e_i; lf = ef;
    end
    tick();
    total++;
    if (done !== 1'b0 || busy !== 1'b0 || dds_ftw !== lf) begin
      bad++;
      $display("FAIL after_done: done=%b busy=%b ftw=%h want done=0 busy=0 ftw=%h", done, busy, dds_ftw, lf);
    end
  endtask

  task automatic test_reset();
    #2 reset_n = 1'b0;
    tick(); tick();
    total++;
    if (dds_ftw !== '0 || busy !== 1'b0 || done !== 1'b0 || res_valid !== 1'b0 ||
        res_i !== '0 || res_q !== '0 || res_idx !== '0) begin
      bad++;
      $display("FAIL reset_values: ftw=%h busy=%b done=%b valid=%b i=%h q=%h idx=%h want all 0",
               dds_ftw, busy, done, res_valid, res_i, res_q, res_idx);
    end
    #2 reset_n = 1'b1;
    tick();
    ftw_start = 32'h1234_5678; n_points = NW'(2); settle = '0; n_avg = AW'(1);
    start = 1'b1;
    tick();
    start = 1'b0;
    #3 reset_n = 1'b0;
    #1;
    total++;
    if (busy !== 1'b0 || dds_ftw !== '0) begin
      bad++;
      $display("FAIL async_reset: busy=%b ftw=%h want busy=0 ftw=0", busy, dds_ftw);
    end
    #2 reset_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    logic [SW-1:0] li; logic [31:0] lf;
    run_sweep(32'h1000, 32'h100, 3, 2, 4, 48, 0, 1'b1, DW'(5), DW'(-3), 1'b0, li, lf);
    total++;
    if (li !== SW'(20) || lf !== 32'h1200) begin
      bad++;
      $display("FAIL basic_last: i=%0d ftw=%h want i=20 ftw=00001200", $signed(li), lf);
    end
  endtask

  task automatic test_backpressure();
    logic [SW-1:0] li; logic [31:0] lf;
    run_sweep($urandom, $urandom, 2, 1, 3, 2, 500, 1'b0, '0, '0, 1'b0, li, lf);
  endtask

  task automatic test_wrap();
    logic [SW-1:0] li; logic [31:0] lf;
    longint m;
    m = -(longint'(1) << 30);
    run_sweep(32'hFFFF_FF80, 32'h100, 2, 0, 255, 1, 0, 1'b1, DW'(m), DW'($urandom), 1'b0, li, lf);
    total++;
    if (li !== SW'(-64'sd273804165120) || lf !== 32'h0000_0080) begin
      bad++;
      $display("FAIL wrap: i=%0d ftw=%h want i=-273804165120 ftw=00000080", $signed(li), lf);
    end
  endtask

  task automatic test_abort();
    logic [SW-1:0] li; logic [31:0] lf;
    bit saw_done;
    ftw_start = 32'hABC0_0000; ftw_step = 32'h10; n_points = NW'(3); settle = AW'(1); n_avg = AW'(4);
    start = 1'b1; tick(); start = 1'b0;
    tick();
    for (int k = 0; k < 5; k++) begin
      strobe_in = 1'b1; i_in = DW'($urandom); tick(); strobe_in = 1'b0; tick();
    end
    res_ready = 1'b1; tick(); res_ready = 1'b0;
    tick();
    for (int k = 0; k < 3; k++) begin
      strobe_in = 1'b1; tick(); strobe_in = 1'b0; tick();
    end
    total++;
    if (busy !== 1'b1 || res_idx !== NW'(1) || res_valid !== 1'b0) begin
      bad++;
      $display("FAIL pre_abort: busy=%b idx=%0d valid=%b want busy=1 idx=1 valid=0", busy, res_idx, res_valid);
    end
    abort = 1'b1; tick(); abort = 1'b0;
    total++;
    if (busy !== 1'b0 || res_valid !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL abort: busy=%b valid=%b done=%b want 0 0 0", busy, res_valid, done);
    end
    saw_done = 1'b0;
    for (int c = 0; c < 8; c++) begin
      strobe_in = c[0]; tick();
      if (done !== 1'b0 || busy !== 1'b0 || res_valid !== 1'b0) saw_done = 1'b1;
    end
    strobe_in = 1'b0;
    total++;
    if (saw_done) begin
      bad++;
      $display("FAIL abort_idle: activity after abort, done=%b busy=%b valid=%b want 0 0 0", done, busy, res_valid);
    end
    run_sweep(32'h0000_5000, 32'h20, 2, 1, 2, 0, -3, 1'b0, '0, '0, 1'b0, li, lf);
  endtask

  task automatic test_zero();
    logic [SW-1:0] li; logic [31:0] lf;
    run_sweep($urandom, $urandom, 0, 0, 0, 0, 0, 1'b0, '0, '0, 1'b0, li, lf);
    start = 1'b1; abort = 1'b1; ftw_start = 32'hDEAD_BEEF;
    tick();
    start = 1'b0; abort = 1'b0;
    total++;
    if (busy !== 1'b0 || dds_ftw !== lf) begin
      bad++;
      $display("FAIL start_abort: busy=%b ftw=%h want busy=0 ftw=%h", busy, dds_ftw, lf);
    end
    for (int c = 0; c < 4; c++) begin strobe_in = 1'b1; tick(); end
    strobe_in = 1'b0;
    total++;
    if (res_valid !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL idle_strobe: valid=%b busy=%b want 0 0", res_valid, busy);
    end
  endtask

  task automatic test_random();
    logic [SW-1:0] li; logic [31:0] lf;
    int na;
    for (int r = 0; r < 8; r++) begin
      na = (r == 3) ? 0 : $urandom_range(1, 6);
      run_sweep($urandom, $urandom, $urandom_range(1, 4), $urandom_range(0, 3), na,
                0, -6, 1'b0, '0, '0, 1'b1, li, lf);
    end
  endtask

`ifdef SWEEP_CTRL_TIMEOUT_EN
  task automatic test_timeout();
    int cnt;
    bit saw_done;
    ftw_start = 32'h77; n_points = NW'(1); settle = '0; n_avg = AW'(4);
    start = 1'b1; tick(); start = 1'b0;
    tick();
    for (int k = 0; k < 2; k++) begin strobe_in = 1'b1; tick(); strobe_in = 1'b0; tick(); end
    cnt = 1; saw_done = 1'b0;
    while (busy === 1'b1 && cnt < 70000) begin
      tick();
      cnt++;
      if (done !== 1'b0) saw_done = 1'b1;
    end
    total++;
    if (err !== 1'b1 || busy !== 1'b0 || saw_done || cnt < 65530 || cnt > 65540) begin
      bad++;
      $display("FAIL timeout: err=%b busy=%b done_seen=%b cycles=%0d want err=1 busy=0 done_seen=0 cycles~65536",
               err, busy, saw_done, cnt);
    end
    start = 1'b1; tick(); start = 1'b0;
    total++;
    if (err !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL err_clear: err=%b busy=%b want err=0 busy=1", err, busy);
    end
    abort = 1'b1; tick(); abort = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_wrap();
    test_abort();
    test_zero();
    test_random();
`ifdef SWEEP_CTRL_TIMEOUT_EN
    test_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
